// File: rtl/phase_sequencer.sv
// Intersection phase sequencer: GREEN -> YELLOW -> ALL_RED -> next GREEN, with
// demand-weighted direction choice, min/max green timing and emergency preemption.
module phase_sequencer #(
    parameter int CNT_W     = 8,
    parameter int TMR_W     = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*CNT_W-1:0] lane,
    input  logic               emerg_req,
    input  logic [1:0]         emerg_dir,
    output logic [7:0]         green,
    output logic [7:0]         yellow,
    output logic [1:0]         cur_dir,
    output logic               phase_start
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } stateT;

    localparam logic [TMR_W-1:0] MinGreenT  = TMR_W'(MIN_GREEN);
    localparam logic [TMR_W-1:0] MaxGreenT  = TMR_W'(MAX_GREEN);
    localparam logic [TMR_W-1:0] YellowLoad = TMR_W'(YELLOW - 1);
    localparam logic [TMR_W-1:0] AllRedLoad = TMR_W'(ALL_RED - 1);
    localparam logic [TMR_W-1:0] TmrOne     = TMR_W'(1);

    stateT            stateReg, stateNext;
    logic [TMR_W-1:0] timerReg, timerNext;
    logic [TMR_W-1:0] greenCntReg, greenCntNext;
    logic [1:0]       curDirReg, curDirNext;
    logic [7:0]       greenNext, yellowNext;
    logic             phaseStartNext;

    logic [CNT_W:0]   dirSum [4];
    logic [3:0]       dirBusy;
    logic [1:0]       cand1, cand2, cand3, pickDir;
    logic             otherDemand, curBusy, emergOther, emergHold;

    function automatic logic [7:0] dirMask(input logic [1:0] d);
        return 8'h03 << {d, 1'b0};
    endfunction

    // Each direction owns two adjacent lanes; the extra bit keeps the sum from wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            assign dirSum[gi]  = {1'b0, lane[(2*gi)*CNT_W +: CNT_W]}
                               + {1'b0, lane[(2*gi+1)*CNT_W +: CNT_W]};
            assign dirBusy[gi] = |dirSum[gi];
        end
    endgenerate

    assign otherDemand = |(dirBusy & ~(4'b0001 << curDirReg));
    assign curBusy     = dirBusy[curDirReg];
    assign emergOther  = emerg_req && (emerg_dir != curDirReg);
    assign emergHold   = emerg_req && (emerg_dir == curDirReg);

    assign cand1 = curDirReg + 2'd1;
    assign cand2 = curDirReg + 2'd2;
    assign cand3 = curDirReg + 2'd3;

    // Strict compare keeps ties with the candidate nearest in rotation.
    always_comb begin
        pickDir = cand1;
        if (dirSum[cand2] > dirSum[pickDir]) pickDir = cand2;
        if (dirSum[cand3] > dirSum[pickDir]) pickDir = cand3;
    end

    always_comb begin
        stateNext      = stateReg;
        timerNext      = timerReg;
        greenCntNext   = greenCntReg;
        curDirNext     = curDirReg;
        phaseStartNext = 1'b0;
        case (stateReg)
            ST_GREEN: begin
                if (emergOther
                    || (greenCntReg >= MinGreenT && !curBusy && otherDemand)
                    || (greenCntReg >= MaxGreenT && otherDemand && !emergHold)) begin
                    stateNext = ST_YELLOW;
                    timerNext = YellowLoad;
                end else if (greenCntReg < MaxGreenT) begin
                    greenCntNext = greenCntReg + TmrOne;
                end
            end
            ST_YELLOW: begin
                if (timerReg == '0) begin
                    stateNext = ST_ALLRED;
                    timerNext = AllRedLoad;
                end else begin
                    timerNext = timerReg - TmrOne;
                end
            end
            ST_ALLRED: begin
                if (timerReg == '0) begin
                    stateNext      = ST_GREEN;
                    timerNext      = '0;
                    curDirNext     = emerg_req ? emerg_dir : pickDir;
                    greenCntNext   = TmrOne;
                    phaseStartNext = 1'b1;
                end else begin
                    timerNext = timerReg - TmrOne;
                end
            end
            default: begin
                stateNext = ST_ALLRED;
                timerNext = AllRedLoad;
            end
        endcase
    end

    // Lamp outputs are decoded from the upcoming state so they can be registered.
    always_comb begin
        greenNext  = (stateNext == ST_GREEN)  ? dirMask(curDirNext) : 8'h00;
        yellowNext = (stateNext == ST_YELLOW) ? dirMask(curDirNext) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg    <= ST_ALLRED;
            timerReg    <= AllRedLoad;
            greenCntReg <= '0;
            curDirReg   <= 2'd3;
            green       <= 8'h00;
            yellow      <= 8'h00;
            phase_start <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            timerReg    <= timerNext;
            greenCntReg <= greenCntNext;
            curDirReg   <= curDirNext;
            green       <= greenNext;
            yellow      <= yellowNext;
            phase_start <= phaseStartNext;
        end
    end

    assign cur_dir = curDirReg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios then random traffic, compared each
// cycle against a remaining-cycles phase model.
module tb_phase_sequencer;

    localparam int CNT_W     = 8;
    localparam int TMR_W     = 8;
    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 16;
    localparam int YELLOW    = 2;
    localparam int ALL_RED   = 1;

    localparam int PH_GREEN  = 0;
    localparam int PH_YELLOW = 1;
    localparam int PH_ALLRED = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [8*CNT_W-1:0] lane = '0;
    logic               emerg_req = 1'b0;
    logic [1:0]         emerg_dir = 2'd0;
    logic [7:0]         green, yellow;
    logic [1:0]         cur_dir;
    logic               phase_start;

    phase_sequencer #(
        .CNT_W(CNT_W), .TMR_W(TMR_W), .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN), .YELLOW(YELLOW), .ALL_RED(ALL_RED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lane(lane), .emerg_req(emerg_req),
        .emerg_dir(emerg_dir), .green(green), .yellow(yellow),
        .cur_dir(cur_dir), .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int cycleNo = 0;
    int phaseNo = 0;

    // Reference model: phase, cycles still to spend in it, direction, green age.
    int mPhase = PH_ALLRED;
    int mLeft  = ALL_RED;
    int mDir   = 3;
    int mCnt   = 0;
    bit mStart = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycleNo, obs, exp);
    endtask

    task automatic modelStep();
        int  sum [4];
        bit  other;
        int  best;
        mStart = 1'b0;
        for (int d = 0; d < 4; d++)
            sum[d] = int'(lane[(2*d)*CNT_W +: CNT_W]) + int'(lane[(2*d+1)*CNT_W +: CNT_W]);
        other = 1'b0;
        for (int d = 0; d < 4; d++)
            if (d != mDir && sum[d] > 0) other = 1'b1;
        if (!rst_n) begin
            mPhase = PH_ALLRED; mLeft = ALL_RED; mDir = 3; mCnt = 0;
        end else if (mPhase == PH_GREEN) begin
            if ((emerg_req && int'(emerg_dir) != mDir)
                || (mCnt >= MIN_GREEN && sum[mDir] == 0 && other)
                || (mCnt >= MAX_GREEN && other && !(emerg_req && int'(emerg_dir) == mDir))) begin
                mPhase = PH_YELLOW; mLeft = YELLOW;
            end else if (mCnt < MAX_GREEN) begin
                mCnt++;
            end
        end else begin
            mLeft--;
            if (mLeft == 0 && mPhase == PH_YELLOW) begin
                mPhase = PH_ALLRED; mLeft = ALL_RED;
            end else if (mLeft == 0) begin
                if (emerg_req) begin
                    best = int'(emerg_dir);
                end else begin
                    best = (mDir + 1) % 4;
                    for (int k = 2; k <= 3; k++)
                        if (sum[(mDir + k) % 4] > sum[best]) best = (mDir + k) % 4;
                end
                mPhase = PH_GREEN; mDir = best; mCnt = 1; mStart = 1'b1;
            end
        end
    endtask

    task automatic stepAndCheck();
        logic [7:0] m;
        modelStep();
        @(posedge clk);
        #1;
        cycleNo++;
        m = 8'h03 << (2 * mDir);
        check("green",       32'(green),       (mPhase == PH_GREEN)  ? 32'(m) : 32'h0);
        check("yellow",      32'(yellow),      (mPhase == PH_YELLOW) ? 32'(m) : 32'h0);
        check("cur_dir",     32'(cur_dir),     32'(mDir));
        check("phase_start", 32'(phase_start), 32'(mStart));
        if (phase_start === 1'b1) begin
            phaseNo++;
            $display("phase %0d cycle %0d: GREEN dir %0d green=%02h", phaseNo, cycleNo, cur_dir, green);
        end
    endtask

    task automatic setLane(input int i, input int v);
        lane[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    initial begin
        // Reset then idle: one all-red cycle, N green held forever.
        rst_n = 1'b0;
        repeat (2) stepAndCheck();
        rst_n = 1'b1;
        repeat (30) stepAndCheck();

        // Demand appears only on E: N yields at min green.
        setLane(2, 5);
        repeat (20) stepAndCheck();

        // Demand everywhere: max-green rotation with S/W tie.
        lane = '0;
        setLane(0, 9); setLane(2, 3); setLane(4, 7); setLane(6, 7);
        repeat (60) stepAndCheck();

        // Emergency to W holds W despite heavy N demand.
        lane = '0;
        setLane(0, 50);
        emerg_req = 1'b1; emerg_dir = 2'd3;
        repeat (40) stepAndCheck();

        // Saturated sums: N (510) must beat E (256) when leaving W.
        emerg_req = 1'b0;
        lane = '0;
        setLane(0, 8'hFF); setLane(1, 8'hFF); setLane(2, 8'hFF); setLane(3, 8'h01);
        repeat (25) stepAndCheck();

        // Reset in mid-phase, then restart.
        setLane(2, 4);
        repeat (3) stepAndCheck();
        rst_n = 1'b0;
        stepAndCheck();
        rst_n = 1'b1;
        lane = '0;
        repeat (10) stepAndCheck();

        // Random traffic with occasional emergencies and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 8; i++)
                    setLane(i, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : 0);
                if ($urandom_range(0, 15) == 0)
                    for (int i = 0; i < 8; i++) setLane(i, 255);
            end
            if ($urandom_range(0, 39) == 0) emerg_req = ~emerg_req;
            if ($urandom_range(0, 9) == 0) emerg_dir = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 199) != 0);
            stepAndCheck();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
